// File: rtl/btn_event_scheduler_pkg.sv
// Shared types and sizing helpers for the button event scheduler and its arbiter.
package btn_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      COOL  = 2'd2
   } sched_state_e;

   // Width of a counter that must hold values up to max(a, b).
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      if (m < 1) begin
         return 1;
      end
      return $clog2(m + 1);
   endfunction

   localparam int DEFAULT_CNT_W = cnt_width(100000, 50000000);

endpackage

// File: rtl/btn_event_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
   parameter int N  = 5,
   parameter int IW = 3
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] grant,
   output logic          any
);

   always_comb begin
      int idx;
      idx   = 0;
      grant = '0;
      any   = 1'b0;
      // Walk from farthest to nearest so the nearest hit is written last.
      for (int k = N - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= N) begin
            idx = idx - N;
         end
         if (req[idx[IW-1:0]]) begin
            grant = idx[IW-1:0];
            any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/btn_event_scheduler.sv
// Serializes button press events round-robin over valid/ready with a cooldown gap.
// Optional hold-to-repeat is enabled by defining BTN_REPEAT_EN.
module btn_event_scheduler
   import btn_sched_pkg::*;
#(
   parameter int NUM_BTN    = 5,
   parameter int ID_W       = 3,
   parameter int COOLDOWN   = 100000,
   parameter int REPEAT_DLY = 50000000,
   parameter int REPEAT_PER = 10000000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn_pulse,
   input  logic [NUM_BTN-1:0] btn_level,
   output logic               evt_valid,
   output logic [ID_W-1:0]    evt_id,
   input  logic               evt_ready,
   output logic [NUM_BTN-1:0] pending,
   output logic               dropped
);

   localparam int CNT_W = cnt_width(COOLDOWN, REPEAT_DLY);
   localparam logic [CNT_W-1:0] COOL_LOAD = (COOLDOWN > 0) ? CNT_W'(COOLDOWN - 1) : '0;

   sched_state_e       state_q;
   logic               evt_valid_q;
   logic [ID_W-1:0]    evt_id_q;
   logic [ID_W-1:0]    rr_ptr_q;
   logic [CNT_W-1:0]   cool_q;
   logic [NUM_BTN-1:0] pending_q;
   logic [NUM_BTN-1:0] pending_d;
   logic               dropped_q;
   logic               dropped_d;

   logic [NUM_BTN-1:0] rep_set;
   logic [NUM_BTN-1:0] set_mask;
   logic [NUM_BTN-1:0] clr_mask;
   logic               handshake;
   logic [ID_W-1:0]    grant;
   logic               any_pending;

   assign handshake = evt_valid_q & evt_ready;
   assign clr_mask  = handshake ? (NUM_BTN'(1) << evt_id_q) : '0;
   assign set_mask  = btn_pulse | rep_set;

   // A new press beats the clear of the event being accepted this cycle.
   assign pending_d = (pending_q & ~clr_mask) | set_mask;
   assign dropped_d = |(set_mask & pending_q & ~clr_mask);

   rr_pick #(
      .N  (NUM_BTN),
      .IW (ID_W)
   ) u_pick (
      .req   (pending_q),
      .ptr   (rr_ptr_q),
      .grant (grant),
      .any   (any_pending)
   );

`ifdef BTN_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_FIRE   = CNT_W'(REPEAT_DLY);
   localparam logic [CNT_W-1:0] REP_RELOAD = CNT_W'(REPEAT_DLY - REPEAT_PER);

   generate
      for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_hold
         logic [CNT_W-1:0] hold_q;
         logic [CNT_W-1:0] hold_d;
         logic             fire;

         // Reloading to DLY-PER makes every later fire land PER cycles apart.
         assign fire   = btn_level[gi] && ((hold_q + CNT_W'(1)) == REP_FIRE);
         assign hold_d = !btn_level[gi] ? '0 :
                         fire           ? REP_RELOAD :
                                          hold_q + CNT_W'(1);
         assign rep_set[gi] = fire;

         always_ff @(posedge clk) begin
            if (rst) begin
               hold_q <= '0;
            end else begin
               hold_q <= hold_d;
            end
         end
      end
   endgenerate
`else
   logic unused_level;
   assign rep_set      = '0;
   assign unused_level = ^{btn_level, REPEAT_PER[0]};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         evt_valid_q <= 1'b0;
         evt_id_q    <= '0;
         rr_ptr_q    <= '0;
         cool_q      <= '0;
         pending_q   <= '0;
         dropped_q   <= 1'b0;
      end else begin
         pending_q <= pending_d;
         dropped_q <= dropped_d;
         unique case (state_q)
            IDLE: begin
               if (any_pending) begin
                  evt_id_q    <= grant;
                  evt_valid_q <= 1'b1;
                  state_q     <= ISSUE;
               end
            end
            ISSUE: begin
               if (handshake) begin
                  evt_valid_q <= 1'b0;
                  rr_ptr_q    <= (evt_id_q == ID_W'(NUM_BTN - 1)) ? '0 : evt_id_q + ID_W'(1);
                  if (COOLDOWN == 0) begin
                     state_q <= IDLE;
                  end else begin
                     cool_q  <= COOL_LOAD;
                     state_q <= COOL;
                  end
               end
            end
            COOL: begin
               if (cool_q == '0) begin
                  state_q <= IDLE;
               end else begin
                  cool_q <= cool_q - CNT_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign evt_valid = evt_valid_q;
   assign evt_id    = evt_id_q;
   assign pending   = pending_q;
   assign dropped   = dropped_q;

endmodule

// File: tb/tb_btn_event_scheduler.sv
// Self-checking bench for btn_event_scheduler: vector table, corner sequences, random vs. model.
module tb_btn_event_scheduler;

   localparam int N  = 5;
   localparam int IW = 3;
   localparam int CD = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  btn_pulse = '0;
   logic [N-1:0]  btn_level = '0;
   logic          evt_ready = 1'b0;
   logic          evt_valid;
   logic [IW-1:0] evt_id;
   logic [N-1:0]  pending;
   logic          dropped;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   btn_event_scheduler #(
      .NUM_BTN    (N),
      .ID_W       (IW),
      .COOLDOWN   (CD),
      .REPEAT_DLY (8),
      .REPEAT_PER (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_pulse (btn_pulse),
      .btn_level (btn_level),
      .evt_valid (evt_valid),
      .evt_id    (evt_id),
      .evt_ready (evt_ready),
      .pending   (pending),
      .dropped   (dropped)
   );

   typedef struct {
      logic         r;
      logic [N-1:0] p;
      logic         rdy;
      logic         v;
      int           id;   // -1: not checked
      logic [N-1:0] pe;
      logic         d;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, input logic [N-1:0] p, input logic rdy,
                               input logic v, input int id, input logic [N-1:0] pe, input logic d);
      vec_t x;
      x.r = r; x.p = p; x.rdy = rdy; x.v = v; x.id = id; x.pe = pe; x.d = d;
      return x;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      btn_pulse = '0;
      btn_level = '0;
      tick();
      rst = 1'b0;
   endtask

   // Reference model state: pending set, offered event, round-robin pointer, issue time gate.
   bit m_pend[N];
   bit m_off;
   int m_id;
   int m_rr;
   int m_next;
   bit m_drop;
   int m_n;

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
      m_off = 0; m_id = 0; m_rr = 0; m_next = 0; m_drop = 0; m_n = 0;
   endtask

   // Advance the model by one clock edge using the inputs presented for that edge.
   task automatic model_edge(input logic [N-1:0] p, input logic rdy);
      bit np[N];
      bit hs;
      bit drop;
      int pick;
      hs   = m_off && rdy;
      pick = -1;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (m_rr + k) % N;
         if (pick < 0 && m_pend[idx]) pick = idx;
      end
      drop = 0;
      for (int i = 0; i < N; i++) begin
         bit clr;
         clr = hs && (m_id == i);
         if (p[i] && m_pend[i] && !clr) drop = 1;
         np[i] = p[i] || (m_pend[i] && !clr);
      end
      if (hs) begin
         m_off  = 0;
         m_rr   = (m_id + 1) % N;
         m_next = m_n + CD + 1;
      end else if (!m_off && m_n >= m_next && pick >= 0) begin
         m_off = 1;
         m_id  = pick;
      end
      for (int i = 0; i < N; i++) m_pend[i] = np[i];
      m_drop = drop;
      m_n++;
   endtask

   function automatic int model_pend_mask();
      int m;
      m = 0;
      for (int i = 0; i < N; i++) if (m_pend[i]) m = m | (1 << i);
      return m;
   endfunction

   initial begin
      int cnt;
      int n0;
      int n1;
      int nval;

      // Single press and cooldown spacing, then simultaneous presses in rr order.
      tbl.push_back(mk(1, 5'b00000, 1, 0,  0, 5'b00000, 0));
      tbl.push_back(mk(0, 5'b00100, 1, 0, -1, 5'b00100, 0));
      tbl.push_back(mk(0, 5'b00000, 1, 1,  2, 5'b00100, 0));
      tbl.push_back(mk(0, 5'b00000, 1, 0, -1, 5'b00000, 0));
      tbl.push_back(mk(0, 5'b00001, 1, 0, -1, 5'b00001, 0));
      tbl.push_back(mk(0, 5'b00000, 1, 0, -1, 5'b00001, 0));
      tbl.push_back(mk(0, 5'b00000, 1, 0, -1, 5'b00001, 0));
      tbl.push_back(mk(0, 5'b00000, 1, 0, -1, 5'b00001, 0));
      tbl.push_back(mk(0, 5'b00000, 1, 1,  0, 5'b00001, 0));
      tbl.push_back(mk(0, 5'b00000, 1, 0, -1, 5'b00000, 0));
      tbl.push_back(mk(1, 5'b00000, 1, 0,  0, 5'b00000, 0));
      tbl.push_back(mk(0, 5'b10011, 1, 0, -1, 5'b10011, 0));
      tbl.push_back(mk(0, 5'b00000, 1, 1,  0, 5'b10011, 0));
      tbl.push_back(mk(0, 5'b00000, 1, 0, -1, 5'b10010, 0));
      for (int k = 0; k < 4; k++) tbl.push_back(mk(0, 5'b00000, 1, 0, -1, 5'b10010, 0));
      tbl.push_back(mk(0, 5'b00000, 1, 1,  1, 5'b10010, 0));
      tbl.push_back(mk(0, 5'b00000, 1, 0, -1, 5'b10000, 0));
      for (int k = 0; k < 4; k++) tbl.push_back(mk(0, 5'b00000, 1, 0, -1, 5'b10000, 0));
      tbl.push_back(mk(0, 5'b00000, 1, 1,  4, 5'b10000, 0));
      tbl.push_back(mk(0, 5'b00000, 1, 0, -1, 5'b00000, 0));
      tbl.push_back(mk(0, 5'b10001, 1, 0, -1, 5'b10001, 0));
      for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 5'b00000, 1, 0, -1, 5'b10001, 0));
      tbl.push_back(mk(0, 5'b00000, 1, 1,  0, 5'b10001, 0));

      for (int k = 0; k < tbl.size(); k++) begin
         rst       = tbl[k].r;
         btn_pulse = tbl[k].p;
         evt_ready = tbl[k].rdy;
         tick();
         check($sformatf("vec%0d_valid", k), int'(evt_valid), int'(tbl[k].v));
         if (tbl[k].id >= 0) check($sformatf("vec%0d_id", k), int'(evt_id), tbl[k].id);
         check($sformatf("vec%0d_pending", k), int'(pending), int'(tbl[k].pe));
         check($sformatf("vec%0d_dropped", k), int'(dropped), int'(tbl[k].d));
      end
      rst = 1'b0;
      btn_pulse = '0;

      // Backpressure on id 3 for 20 cycles.
      do_reset();
      evt_ready = 1'b0;
      btn_pulse = 5'b01000;
      tick();
      btn_pulse = '0;
      tick();
      check("bp_first_valid", int'(evt_valid), 1);
      check("bp_first_id", int'(evt_id), 3);
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (evt_valid && evt_id == 3'd3) cnt++;
      end
      check("bp_stable_cycles", cnt, 20);
      evt_ready = 1'b1;
      tick();
      check("bp_valid_after", int'(evt_valid), 0);
      check("bp_pending3_cleared", int'(pending[3]), 0);
      $display("bp event id=3 accepted");

      // Re-press of a pending button while id 0 is held in ISSUE.
      do_reset();
      evt_ready = 1'b0;
      btn_pulse = 5'b00001;
      tick();
      btn_pulse = '0;
      tick();
      check("rp_valid_id0", int'(evt_valid && evt_id == 3'd0), 1);
      btn_pulse = 5'b00010;
      tick();
      check("rp_pending_a", int'(pending), 5'b00011);
      check("rp_dropped_a", int'(dropped), 0);
      tick();
      check("rp_pending_b", int'(pending), 5'b00011);
      check("rp_dropped_b", int'(dropped), 1);
      btn_pulse = '0;
      tick();
      check("rp_dropped_c", int'(dropped), 0);
      evt_ready = 1'b1;
      n0 = 0;
      n1 = 0;
      for (int k = 0; k < 30; k++) begin
         if (evt_valid && evt_ready) begin
            $display("rp event id=%0d", evt_id);
            if (evt_id == 3'd0) n0++;
            if (evt_id == 3'd1) n1++;
         end
         tick();
      end
      check("rp_id0_events", n0, 1);
      check("rp_id1_events", n1, 1);

      // Press arriving in the handshake cycle of the same id.
      do_reset();
      evt_ready = 1'b1;
      btn_pulse = 5'b00100;
      tick();
      btn_pulse = '0;
      tick();
      check("col_valid_id2", int'(evt_valid && evt_id == 3'd2), 1);
      btn_pulse = 5'b00100;
      tick();
      btn_pulse = '0;
      check("col_valid_after", int'(evt_valid), 0);
      check("col_pending", int'(pending), 5'b00100);
      check("col_dropped", int'(dropped), 0);
      cnt = 0;
      while (!evt_valid && cnt < 20) begin
         tick();
         cnt++;
      end
      check("col_gap", cnt, CD + 1);
      check("col_second_id", int'(evt_id), 2);
      $display("col event id=%0d gap=%0d", evt_id, cnt);

      // Reset asserted mid-ISSUE discards everything.
      do_reset();
      evt_ready = 1'b0;
      btn_pulse = 5'b01110;
      tick();
      btn_pulse = '0;
      tick();
      check("rst_valid_id1", int'(evt_valid && evt_id == 3'd1), 1);
      rst = 1'b1;
      tick();
      check("rst_valid", int'(evt_valid), 0);
      check("rst_pending", int'(pending), 0);
      rst = 1'b0;
      evt_ready = 1'b1;
      nval = 0;
      for (int k = 0; k < 15; k++) begin
         tick();
         if (evt_valid) nval++;
      end
      check("rst_no_events", nval, 0);

`ifdef BTN_REPEAT_EN
      begin
         int hits[$];
         int exp_hits[4];
         bit prev;
         exp_hits = '{8, 12, 16, 20};
         do_reset();
         evt_ready = 1'b0;
         prev = 1'b0;
         for (int k = 1; k <= 20; k++) begin
            btn_level = 5'b00001;
            tick();
            if ((pending[0] && !prev) || dropped) hits.push_back(k);
            prev = pending[0];
         end
         btn_level = '0;
         check("rep_hit_count", hits.size(), 4);
         for (int k = 0; k < 4 && k < hits.size(); k++) begin
            check($sformatf("rep_hit%0d", k), hits[k], exp_hits[k]);
         end
      end
`endif

      // Randomized traffic against the reference model.
      do_reset();
      model_reset();
      for (int c = 0; c < 800; c++) begin
         logic [N-1:0] p;
         logic         rdy;
         p = '0;
         for (int i = 0; i < N; i++) p[i] = ($urandom_range(0, 7) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         btn_pulse = p;
         evt_ready = rdy;
         if (evt_valid && evt_ready) $display("rnd event id=%0d cycle=%0d", evt_id, c);
         model_edge(p, rdy);
         tick();
         check($sformatf("rnd%0d_valid", c), int'(evt_valid), int'(m_off));
         if (m_off) check($sformatf("rnd%0d_id", c), int'(evt_id), m_id);
         check($sformatf("rnd%0d_pending", c), int'(pending), model_pend_mask());
         check($sformatf("rnd%0d_dropped", c), int'(dropped), int'(m_drop));
      end
      btn_pulse = '0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/btn_event_scheduler.md
Name: btn_event_scheduler

Overview:
Sits between the per-button debounce/one-pulse chains and the game/control FSM.
- Captures single-cycle press events from up to NUM_BTN buttons into a pending register.
- Arbitrates among pending events round-robin and issues one event at a time over a valid/ready handshake.
- Enforces a cooldown gap between issued events, so simultaneous presses are serialized and none are lost.

Parameters:
- NUM_BTN, 5, number of button event inputs (2..8).
- ID_W, 3, width of evt_id; must satisfy 2**ID_W >= NUM_BTN.
- COOLDOWN, 100000, idle clk cycles enforced after each accepted event; 0 disables cooldown.
- REPEAT_DLY, 50000000, hold cycles before auto-repeat starts (used only with BTN_REPEAT_EN).
- REPEAT_PER, 10000000, cycles between auto-repeat events (used only with BTN_REPEAT_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- btn_pulse  in  NUM_BTN  one-cycle press pulses, already debounced and synchronous to clk.
- btn_level  in  NUM_BTN  debounced button levels; used only with BTN_REPEAT_EN.
- evt_valid  out  1  event offered to consumer.
- evt_id  out  ID_W  index of the offered button.
- evt_ready  in  1  consumer accepts the event when high together with evt_valid.
- pending  out  NUM_BTN  registered pending mask, for debug/LEDs.
- dropped  out  1  one-cycle pulse: a press arrived for a button already pending and not being cleared.

Behaviour:
- Reset values: evt_valid=0, evt_id=0, pending=0, dropped=0, rr_ptr=0, cooldown counter=0, state=IDLE. Reset asserted mid-operation discards all pending and in-flight events.
- Pending update, per bit i, every cycle:
  - Set when btn_pulse[i]=1.
  - Cleared when the handshake completes for id i.
  - Set and clear in the same cycle: set wins, so the new press stays pending.
  - btn_pulse[i]=1 while pending[i]=1 and bit i is not being cleared: pending stays 1 and dropped=1 next cycle.
- FSM has three states.
  - IDLE: if pending != 0, select the first set bit scanning upward from rr_ptr with wrap-around. Register evt_id=selected, evt_valid=1, go to ISSUE. Otherwise stay.
  - ISSUE: evt_valid and evt_id are held stable until evt_valid && evt_ready. On handshake:
    - evt_valid=0.
    - pending[evt_id] cleared.
    - rr_ptr = (evt_id+1) mod NUM_BTN.
    - If COOLDOWN=0, go to IDLE. Otherwise load counter=COOLDOWN-1 and go to COOL.
  - COOL: decrement the counter each cycle; go to IDLE in the cycle the counter reaches 0. Pending still captures presses during COOL.
- Latency: a press at edge t sets pending at t+1. From IDLE, evt_valid rises at edge t+2. Handshake at edge h puts the next evt_valid at h+COOLDOWN+2 (h+2 when COOLDOWN=0).
- evt_ready held high continuously is legal: each event is accepted in its first valid cycle.
- Pulses arriving for bits >= NUM_BTN do not exist; the widths are exact.

Optional Feature:
Macro BTN_REPEAT_EN.
- Defined:
  - Each button has a hold counter that runs while btn_level[i]=1 and clears when btn_level[i]=0.
  - When the counter reaches REPEAT_DLY, it sets pending[i] and reloads so that pending[i] is set again every REPEAT_PER cycles while the button is held.
  - Auto-repeat sets obey the same set-wins and dropped rules as btn_pulse.
- Not defined: btn_level is ignored and no hold counters are synthesized.

Decomposition:
- Package btn_sched_pkg holds:
  - FSM state encoding: IDLE, ISSUE, COOL.
  - Counter width constant, sized to max(COOLDOWN, REPEAT_DLY).
- One natural sub-module: rr_pick.
  - Purely combinational.
  - Inputs: pending mask and rr_ptr. Outputs: grant index and any_pending.
  - Reused by other arbiters in the design.

Test Plan (NUM_BTN=5, COOLDOWN=4, evt_ready=1 unless stated):
- Reset then single press btn_pulse=5'b00100 at edge 10 -> pending=00100 at 11; evt_valid=1, evt_id=2 at 12; pending=0 at 13; next evt_valid is not possible before edge 18.
- Simultaneous btn_pulse=5'b10011 with rr_ptr=0 -> events issued in order id 0, 1, 4, each separated by exactly 4 cooldown cycles plus 2; then rr_ptr=0.
- Backpressure: evt_ready=0 for 20 cycles after evt_valid for id 3 -> evt_valid and evt_id=3 stable all 20 cycles; on evt_ready=1 the handshake clears pending[3].
- Re-press of a pending button: btn_pulse[1] at t, again at t+1 while held in ISSUE for id 0 -> dropped=1 at t+2, pending[1] remains 1, exactly one id-1 event issued.
- Set/clear collision: btn_pulse[2]=1 in the handshake cycle of id 2 -> pending[2]=1 afterwards; a second id-2 event is issued after cooldown.
- Reset mid-ISSUE with pending=01110 -> next cycle evt_valid=0, pending=0, no events issued afterwards; with BTN_REPEAT_EN, REPEAT_DLY=8, REPEAT_PER=4, btn_level[0] held for 20 cycles after reset is released -> events for id 0 at hold counts 8, 12, 16, 20.
